// File: rtl/char_write_arbiter_if.sv
// Editor write handshake and character-memory write port of the
// character write arbiter, bundled as one interface.
interface char_write_arbiter_if;
    // Editor write request channel
    logic       e_valid;
    logic       e_ready;
    logic [6:0] e_x;
    logic [5:0] e_y;
    logic [6:0] e_ascii;
    logic [5:0] e_col;

    // Character-memory write port
    logic [6:0] m_x;
    logic [5:0] m_y;
    logic [6:0] m_ascii;
    logic [5:0] m_col;
    logic       m_wren;

    // Arbiter side: consumes editor requests, drives the memory port
    modport slave (
        input  e_valid, e_x, e_y, e_ascii, e_col,
        output e_ready,
        output m_x, m_y, m_ascii, m_col, m_wren
    );

    // Editor / memory side: issues requests, observes the memory port
    modport master (
        output e_valid, e_x, e_y, e_ascii, e_col,
        input  e_ready,
        input  m_x, m_y, m_ascii, m_col, m_wren
    );
endinterface

// File: rtl/char_write_arbiter.sv
// Character write arbiter: merges editor cell writes (buffered in a
// 2-entry FIFO) with full-screen clears onto one character-memory
// write port. A clear sweeps every cell of the latched geometry in
// row-major order, then pulses clr_done; editor writes queued meanwhile
// drain afterwards in arrival order.
module char_write_arbiter #(
    parameter int SCOLS = 80,
    parameter int SROWS = 59,
    parameter int LCOLS = 40,
    parameter int LROWS = 29,
    parameter int FILL  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sL,
    input  logic                  clr_start,
    input  logic [5:0]            clr_col,
    char_write_arbiter_if.slave   bus,
    output logic                  busy,
    output logic                  clr_done
);

    localparam logic [6:0] SC_LAST   = 7'(SCOLS - 1);
    localparam logic [5:0] SR_LAST   = 6'(SROWS - 1);
    localparam logic [6:0] LC_LAST   = 7'(LCOLS - 1);
    localparam logic [5:0] LR_LAST   = 6'(LROWS - 1);
    localparam logic [6:0] FILL_CODE = 7'(FILL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [6:0] x;
        logic [5:0] y;
        logic [6:0] ascii;
        logic [5:0] col;
    } entry_t;

    state_t     state;
    state_t     state_nx;

    // Editor FIFO storage and bookkeeping
    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    entry_t     head;

    // Clear sweep state
    logic       clr_accept;
    logic       lg;
    logic [5:0] lat_col;
    logic [6:0] cx;
    logic [5:0] cy;
    logic [6:0] col_last;
    logic [5:0] row_last;
    logic       last_cell;

    // Ready depends only on the registered count, so a pop in the same
    // cycle never makes room for a push.
    assign bus.e_ready = (count != 2'd2);
    assign push        = bus.e_valid & bus.e_ready;
    assign head        = mem[rd_ptr];

    assign busy = (state != IDLE) | (count != 2'd0);

    // Sweep limits follow the geometry latched at clear acceptance
    assign col_last  = lg ? LC_LAST : SC_LAST;
    assign row_last  = lg ? LR_LAST : SR_LAST;
    assign last_cell = (cx == col_last) && (cy == row_last);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, clear acceptance and pop decision
    always_comb begin
        state_nx   = state;
        clr_accept = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    clr_accept = 1'b1;
                    state_nx   = CLEAR;
                end else if (count != 2'd0) begin
                    pop = 1'b1;
                end
            end
            CLEAR: begin
                if (last_cell) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // FIFO storage write; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{x: bus.e_x, y: bus.e_y, ascii: bus.e_ascii, col: bus.e_col};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Clear parameters latch and row-major cell counter
    always_ff @(posedge clk) begin
        if (reset) begin
            lg      <= 1'b0;
            lat_col <= '0;
            cx      <= '0;
            cy      <= '0;
        end else if (clr_accept) begin
            lg      <= sL;
            lat_col <= clr_col;
            cx      <= '0;
            cy      <= '0;
        end else if (state == CLEAR) begin
            if (cx == col_last) begin
                cx <= '0;
                cy <= (cy == row_last) ? '0 : cy + 6'd1;
            end else begin
                cx <= cx + 7'd1;
            end
        end
    end

    // Registered memory port and clear-done pulse. The pulse is taken
    // from DONE one cycle late so it lines up with the first idle cycle
    // of m_wren after the final clear write.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.m_x     <= '0;
            bus.m_y     <= '0;
            bus.m_ascii <= '0;
            bus.m_col   <= '0;
            bus.m_wren  <= 1'b0;
            clr_done    <= 1'b0;
        end else begin
            bus.m_wren <= 1'b0;
            clr_done   <= (state == DONE);
            if (state == CLEAR) begin
                bus.m_x     <= cx;
                bus.m_y     <= cy;
                bus.m_ascii <= FILL_CODE;
                bus.m_col   <= lat_col;
                bus.m_wren  <= 1'b1;
            end else if (pop) begin
                bus.m_x     <= head.x;
                bus.m_y     <= head.y;
                bus.m_ascii <= head.ascii;
                bus.m_col   <= head.col;
                bus.m_wren  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/char_write_arbiter.md
CHAR_WRITE_ARBITER -- requirements
Module: char_write_arbiter

Interface
REQ-001 SHALL have parameter SCOLS, default 80: small-font column count.
REQ-002 SHALL have parameter SROWS, default 59: small-font row count.
REQ-003 SHALL have parameter LCOLS, default 40: large-font column count.
REQ-004 SHALL have parameter LROWS, default 29: large-font row count.
REQ-005 SHALL have parameter FILL, default 32: ASCII code written by a clear.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-008 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-009 SHALL have port sL  in  1  1 = large-font geometry, 0 = small.
REQ-010 SHALL have port clr_start  in  1  one-cycle request to clear the screen.
REQ-011 SHALL have port clr_col  in  6  fill colour for the clear.
REQ-012 SHALL have port e_valid  in  1  editor write request.
REQ-013 SHALL have port e_ready  out  1  arbiter can accept an editor write.
REQ-014 SHALL have ports e_x (7), e_y (6), e_ascii (7), e_col (6), all in: editor write cell, char and colour.
REQ-015 SHALL have ports m_x (7), m_y (6), m_ascii (7), m_col (6), m_wren (1), all out and registered: character-memory write port.
REQ-016 SHALL have port busy  out  1  clear in progress or editor writes pending.
REQ-017 SHALL have port clr_done  out  1  one-cycle pulse when a clear finishes.

Function
REQ-018 SHALL hold editor writes in a 2-entry FIFO (x, y, ascii, col); push on rising edge when e_valid & e_ready.
REQ-019 SHALL drive e_ready = 1 iff FIFO count < 2, from registered count only; no push when full, even in a pop cycle.
REQ-020 SHALL use FSM states IDLE, CLEAR, DONE.
REQ-021 In IDLE with FIFO non-empty and no clr_start: SHALL pop the head, register it onto m_*, and assert m_wren for exactly one cycle per entry; one pop per cycle max.
REQ-022 Latency: entry pushed at edge N, FIFO previously empty, IDLE -> m_wren high in the cycle after edge N+1.
REQ-023 SHALL keep FIFO order; editor coordinates pass through unclipped.
REQ-024 SHALL accept clr_start only in IDLE, and ignore it in CLEAR/DONE.
REQ-025 On acceptance SHALL latch sL and clr_col, enter CLEAR, and not pop that cycle; clear has priority over pending FIFO entries.
REQ-026 In CLEAR SHALL write one cell per cycle, row-major: x 0..cols-1 inner, y 0..rows-1 outer, m_ascii = FILL, m_col = latched colour, m_wren = 1; cols/rows from latched sL.
REQ-027 A clear SHALL produce exactly SCOLS*SROWS (4720) or LCOLS*LROWS (1160) consecutive m_wren cycles; sL changes mid-clear have no effect.
REQ-028 After the last cell SHALL enter DONE for one cycle: m_wren = 0, clr_done = 1; then return to IDLE.
REQ-029 During CLEAR/DONE the FIFO SHALL keep accepting up to 2 entries and SHALL NOT pop; held entries drain in IDLE afterwards.
REQ-030 Simultaneous clr_start and editor push in IDLE: push SHALL be accepted and written after the clear completes.
REQ-031 busy SHALL equal (state != IDLE) | (FIFO count != 0), combinational from registers.
REQ-032 m_wren SHALL be 0 in every cycle with no pop and no clear write; m_* data holds its last value when m_wren = 0.

Reset
REQ-033 On reset SHALL force IDLE, empty FIFO, zero clear counters, and set m_x, m_y, m_ascii, m_col, m_wren, clr_done to 0; e_ready = 1, busy = 0 in the following cycle.
REQ-034 Reset mid-clear or with pending FIFO entries SHALL abort all activity; no further m_wren until new requests arrive.

Verification
REQ-035 One editor write (3,2,'A'=65,col 5) in IDLE -> single m_wren cycle with m_x=3, m_y=2, m_ascii=65, m_col=5, two edges after acceptance.
REQ-036 sL=1, clr_start, clr_col=7 -> 1160 consecutive m_wren cycles, (0,0) to (39,28), ascii 32, col 7, then clr_done pulse, busy low.
REQ-037 Small clear with sL toggled at cycle 100 -> exactly 4720 writes, last cell (79,58).
REQ-038 Three back-to-back e_valid during CLEAR -> e_ready low after two accepted; both written in order after clr_done, third accepted once space frees.
REQ-039 clr_start asserted during CLEAR -> ignored; exactly one clr_done.
REQ-040 reset at clear cycle 500 with 2 FIFO entries -> m_wren 0 next cycle, busy 0, e_ready 1, no later writes.
